life_grid_engine: RTL and testbench

- Parametrised successor to the single-cell life rule: a self-contained X-by-Y cellular-automaton engine holding a double-buffered grid.
- Computes N generations on command, one row per clock, with a parametrised birth/survive rule and a selectable toroidal or dead-border edge mode.
- Host loads and reads the grid through row ports and launches runs with a start/busy/done handshake.

---
 rtl/life_grid_engine.sv | 171 +++++++++++++++++
 tb/tb_life_grid_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
// life_grid_engine: double-buffered X-by-Y cellular automaton. Computes one row of the next
// generation per clock and swaps the visible bank after each complete generation. The
// birth/survive rule is set by parameters. Edges are either toroidal or treated as dead cells.
module life_grid_engine #(
   parameter int unsigned X       = 8,
   parameter int unsigned Y       = 8,
   parameter int unsigned LOG2X   = 3,
   parameter int unsigned LOG2Y   = 3,
   parameter logic [8:0]  BIRTH   = 9'b000001000,
   parameter logic [8:0]  SURVIVE = 9'b000001100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [LOG2Y-1:0] wr_row,
   input  logic [X-1:0]     wr_data,
   input  logic [LOG2Y-1:0] rd_row,
   output logic [X-1:0]     rd_data,
   input  logic             start,
   input  logic [7:0]       gens,
   input  logic             wrap_mode,
   output logic             busy,
   output logic             done,
   output logic [7:0]       gen_count
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   localparam logic [LOG2Y-1:0] LastRow = LOG2Y'(Y - 1);

   state_e           state_q, state_d;
   logic [X-1:0]     bank_q [2][Y];
   logic [X-1:0]     bank_d [2][Y];
   logic             vis_q, vis_d;
   logic [LOG2Y-1:0] row_q, row_d;
   logic [7:0]       gens_q, gens_d;
   logic             wrap_q, wrap_d;
   logic [7:0]       gen_cnt_q, gen_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [X-1:0]     rd_data_q, rd_data_d;

   logic [LOG2Y-1:0] row_up_idx, row_dn_idx;
   logic [X-1:0]     up_row, mid_row, dn_row, new_row;

   // Fetch the three visible rows around the row pointer, blanking rows beyond a dead border.
   always_comb begin
      row_up_idx = (row_q == '0) ? LastRow : row_q - 1'b1;
      row_dn_idx = (row_q == LastRow) ? '0 : row_q + 1'b1;
      up_row     = bank_q[vis_q][row_up_idx];
      mid_row    = bank_q[vis_q][row_q];
      dn_row     = bank_q[vis_q][row_dn_idx];
      if (!wrap_q && (row_q == '0)) up_row = '0;
      if (!wrap_q && (row_q == LastRow)) dn_row = '0;
   end

   // Apply the birth/survive rule to every cell of the current row.
   always_comb begin
      logic [LOG2X-1:0] cc, cl, cr;
      logic             l_ok, r_ok;
      logic [3:0]       nsum;
      cc      = '0;
      cl      = '0;
      cr      = '0;
      l_ok    = 1'b0;
      r_ok    = 1'b0;
      nsum    = '0;
      new_row = '0;
      for (int unsigned i = 0; i < X; i++) begin
         cc   = LOG2X'(i);
         cl   = (i == 0) ? LOG2X'(X - 1) : LOG2X'(i - 1);
         cr   = (i == X - 1) ? '0 : LOG2X'(i + 1);
         // Side neighbours only exist past the border when the grid wraps.
         l_ok = wrap_q || (i != 0);
         r_ok = wrap_q || (i != X - 1);
         nsum = 4'(up_row[cc]) + 4'(dn_row[cc])
              + 4'(l_ok & up_row[cl]) + 4'(l_ok & mid_row[cl]) + 4'(l_ok & dn_row[cl])
              + 4'(r_ok & up_row[cr]) + 4'(r_ok & mid_row[cr]) + 4'(r_ok & dn_row[cr]);
         new_row[i] = mid_row[cc] ? SURVIVE[nsum] : BIRTH[nsum];
      end
   end

   // Next-state logic: host access in idle, row-by-row generation stepping while running.
   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      vis_d     = vis_q;
      row_d     = row_q;
      gens_d    = gens_q;
      wrap_d    = wrap_q;
      gen_cnt_d = gen_cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_data_d = (rd_row <= LastRow) ? bank_q[vis_q][rd_row] : '0;

      unique case (state_q)
         StIdle: begin
            if (wr_en && (wr_row <= LastRow)) bank_d[vis_q][wr_row] = wr_data;
            if (start) begin
               gens_d    = gens;
               wrap_d    = wrap_mode;
               gen_cnt_d = '0;
               row_d     = '0;
               if (gens == 8'd0) begin
                  state_d = StFin;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = StRun;
                  busy_d  = 1'b1;
               end
            end
         end
         StRun: begin
            bank_d[~vis_q][row_q] = new_row;
            if (row_q == LastRow) begin
               // Last row written: the target bank now holds a full generation.
               row_d     = '0;
               vis_d     = ~vis_q;
               gen_cnt_d = gen_cnt_q + 8'd1;
               if ((gen_cnt_q + 8'd1) == gens_q) begin
                  state_d = StFin;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous reset that also clears both grid banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         bank_q    <= '{default: '{default: '0}};
         vis_q     <= 1'b0;
         row_q     <= '0;
         gens_q    <= '0;
         wrap_q    <= 1'b0;
         gen_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         vis_q     <= vis_d;
         row_q     <= row_d;
         gens_q    <= gens_d;
         wrap_q    <= wrap_d;
         gen_cnt_q <= gen_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign gen_count = gen_cnt_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Testbench for life_grid_engine: an 8x8 Conway instance and a 16x5 HighLife instance,
// compared against a cell-by-cell neighbour-counting reference model.
module tb_life_grid_engine;

   localparam logic [8:0] BirthB3  = 9'b000001000;
   localparam logic [8:0] BirthB36 = 9'b001001000;
   localparam logic [8:0] SurvS23  = 9'b000001100;

   logic        clk = 1'b0;
   logic        rst, start, wr_en, wrap, sel;
   logic [2:0]  wr_row, rd_row;
   logic [15:0] wr_data;
   logic [7:0]  gens;
   logic        start_a, start_b, wr_en_a, wr_en_b;
   logic [7:0]  rd_a, gc_a, gc_b;
   logic [15:0] rd_b;
   logic        busy_a, done_a, busy_b, done_b;
   logic [63:0] rd_s;
   logic [7:0]  gc_s;
   logic        busy_s, done_s;

   int          checks = 0;
   int          errors = 0;
   int          w_cur, h_cur;
   logic [8:0]  birth_cur;
   logic [63:0] mdl [64];

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign start_b = start & sel;
   assign wr_en_a = wr_en & ~sel;
   assign wr_en_b = wr_en & sel;
   assign rd_s    = sel ? 64'(rd_b) : 64'(rd_a);
   assign gc_s    = sel ? gc_b : gc_a;
   assign busy_s  = sel ? busy_b : busy_a;
   assign done_s  = sel ? done_b : done_a;

   life_grid_engine dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_row(wr_row), .wr_data(wr_data[7:0]),
      .rd_row(rd_row), .rd_data(rd_a), .start(start_a), .gens(gens), .wrap_mode(wrap),
      .busy(busy_a), .done(done_a), .gen_count(gc_a)
   );

   life_grid_engine #(
      .X(16), .Y(5), .LOG2X(4), .LOG2Y(3), .BIRTH(BirthB36), .SURVIVE(SurvS23)
   ) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_row(wr_row), .wr_data(wr_data),
      .rd_row(rd_row), .rd_data(rd_b), .start(start_b), .gens(gens), .wrap_mode(wrap),
      .busy(busy_b), .done(done_b), .gen_count(gc_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic select(input bit b);
      sel       = b;
      w_cur     = b ? 16 : 8;
      h_cur     = b ? 5 : 8;
      birth_cur = b ? BirthB36 : BirthB3;
   endtask

   task automatic clear_model();
      for (int r = 0; r < 64; r++) mdl[r] = '0;
   endtask

   // One generation computed directly from the rule: count live neighbours of every cell.
   task automatic model_step(input bit wr);
      logic [63:0] nxt [64];
      int n, yy, xx;
      for (int r = 0; r < 64; r++) nxt[r] = '0;
      for (int y = 0; y < h_cur; y++) begin
         for (int x = 0; x < w_cur; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  if (dy != 0 || dx != 0) begin
                     yy = y + dy;
                     xx = x + dx;
                     if (wr) begin
                        yy = (yy + h_cur) % h_cur;
                        xx = (xx + w_cur) % w_cur;
                        n += int'(mdl[yy][xx]);
                     end else if (yy >= 0 && yy < h_cur && xx >= 0 && xx < w_cur) begin
                        n += int'(mdl[yy][xx]);
                     end
                  end
               end
            end
            nxt[y][x] = mdl[y][x] ? SurvS23[n] : birth_cur[n];
         end
      end
      mdl = nxt;
   endtask

   task automatic load_grid();
      for (int r = 0; r < h_cur; r++) begin
         wr_en   = 1'b1;
         wr_row  = 3'(r);
         wr_data = mdl[r][15:0];
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic read_row(input int r, output logic [63:0] v);
      rd_row = 3'(r);
      @(posedge clk); #1;
      v = rd_s;
   endtask

   task automatic read_grid(input string tag);
      logic [63:0] v;
      for (int r = 0; r < h_cur; r++) begin
         read_row(r, v);
         check($sformatf("%s_row%0d", tag, r), v, mdl[r]);
      end
   endtask

   // Launch a run, watch the done pulse timing inside a bounded window, then advance the model.
   task automatic run(input int g, input bit wr, input bit intrude);
      int first = -1;
      int cnt   = 0;
      gens  = 8'(g);
      wrap  = wr;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc <= g * h_cur + 4; cyc++) begin
         if (done_s) begin
            cnt++;
            if (first < 0) first = cyc;
         end
         if (cyc == 1 && g > 0) check("busy_mid", 64'(busy_s), 64'd1);
         if (intrude) begin
            start   = (cyc == 3);
            wr_en   = (cyc == 3);
            wr_row  = 3'd0;
            wr_data = 16'hFFFF;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      wr_en = 1'b0;
      check("done_cycle", 64'(first), 64'(g * h_cur));
      check("done_count", 64'(cnt), 64'd1);
      check("busy_end", 64'(busy_s), 64'd0);
      check("gen_count", 64'(gc_s), 64'(g));
      for (int i = 0; i < g; i++) model_step(wr);
   endtask

   task automatic blinker_model();
      clear_model();
      mdl[3] = 64'h08;
      mdl[4] = 64'h08;
      mdl[5] = 64'h08;
   endtask

   task automatic glider_model();
      clear_model();
      mdl[0] = 64'h02;
      mdl[1] = 64'h04;
      mdl[2] = 64'h07;
   endtask

   initial begin
      logic [63:0] v;
      int          cnt;
      rst = 1'b1; start = 1'b0; wr_en = 1'b0; wrap = 1'b0;
      wr_row = '0; rd_row = '0; wr_data = '0; gens = '0;
      select(1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("reset_busy", 64'(busy_s), 64'd0);
      check("reset_done", 64'(done_s), 64'd0);
      check("reset_gen_count", 64'(gc_s), 64'd0);
      check("reset_rd_data", rd_s, 64'd0);

      // Blinker, one generation: vertical line becomes horizontal.
      blinker_model();
      load_grid();
      run(1, 1'b0, 1'b0);
      read_grid("blinker1");
      read_row(4, v);
      check("blinker1_row4_const", v, 64'h1C);
      read_row(3, v);
      check("blinker1_row3_const", v, 64'h00);

      // Blinker period 2 returns to the loaded pattern.
      blinker_model();
      load_grid();
      run(2, 1'b0, 1'b0);
      read_grid("blinker2");
      read_row(4, v);
      check("blinker2_row4_const", v, 64'h08);

      // Zero generations: immediate done, grid untouched.
      run(0, 1'b0, 1'b0);
      read_grid("gens0");

      // start and wr_en while busy must be ignored.
      run(2, 1'b0, 1'b1);
      read_grid("protocol");

      // Toroidal glider returns to its origin after 32 generations.
      glider_model();
      load_grid();
      run(32, 1'b1, 1'b0);
      read_grid("glider_wrap");
      read_row(2, v);
      check("glider_wrap_row2_const", v, 64'h07);

      // Dead-border glider decays against the corner.
      glider_model();
      load_grid();
      run(32, 1'b0, 1'b0);
      read_grid("glider_dead");

      // Reset in the middle of a run.
      blinker_model();
      load_grid();
      gens  = 8'd3;
      wrap  = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midreset_busy", 64'(busy_s), 64'd0);
      check("midreset_done", 64'(done_s), 64'd0);
      check("midreset_gen_count", 64'(gc_s), 64'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done_s) cnt++;
      end
      check("midreset_no_done", 64'(cnt), 64'd0);
      clear_model();
      read_grid("midreset_grid");

      // HighLife 16x5 against the model with random grids in both edge modes.
      select(1'b1);
      for (int t = 0; t < 20; t++) begin
         for (int m = 0; m < 2; m++) begin
            clear_model();
            for (int r = 0; r < h_cur; r++) mdl[r] = 64'($urandom() & 32'h0000_FFFF);
            load_grid();
            run(10, m[0], 1'b0);
            read_grid($sformatf("hl_t%0d_w%0d", t, m));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
